// File: rtl/sweep_ctrl_if.sv
// Sweep controller bus: run controls plus the driven counter control/status.
// Ports: master = sweep_ctrl side, slave = environment/counter side.
interface sweep_ctrl_if #(
    parameter int N     = 8,
    parameter int DIV_W = 16
);
    logic             start;
    logic             stop;
    logic [DIV_W-1:0] div;
    logic [N-1:0]     start_val;
    logic             max_tick;
    logic             min_tick;
    logic             syn_clr;
    logic             load;
    logic             en;
    logic             up;
    logic [N-1:0]     d;
    logic             busy;
    logic             sweep_done;
    logic [15:0]      sweeps;

    modport master (
        input  start, stop, div, start_val, max_tick, min_tick,
        output syn_clr, load, en, up, d, busy, sweep_done, sweeps
    );

    modport slave (
        output start, stop, div, start_val, max_tick, min_tick,
        input  syn_clr, load, en, up, d, busy, sweep_done, sweeps
    );
endinterface

// File: rtl/sweep_ctrl.sv
// Up/down sweep controller driving an external universal binary counter.
// Ports: clk, reset (sync, active high), bus (sweep_ctrl_if.master).
// Option: define SWEEP_CTRL_SWEEP_CNT_EN to build the saturating sweep counter.
module sweep_ctrl #(
    parameter int N     = 8,
    parameter int DIV_W = 16
) (
    input  logic clk,
    input  logic reset,
    sweep_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN_UP = 2'd2,
        RUN_DN = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [N-1:0]     d_q, d_d;

    logic run;
    logic terminal;
    logic syn_clr;
    logic load;
    logic en;
    logic up;
    logic done;

    assign run      = (state_q == RUN_UP) || (state_q == RUN_DN);
    assign terminal = run && (presc_q == div_q);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        d_d     = d_q;
        presc_d = presc_q;
        syn_clr = 1'b0;
        load    = 1'b0;
        en      = 1'b0;
        up      = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                presc_d = '0;
                // stop beats start: nothing is captured
                if (bus.start && !bus.stop) begin
                    div_d   = bus.div;
                    d_d     = bus.start_val;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                presc_d = '0;
                if (bus.stop) begin
                    syn_clr = 1'b1;
                    state_d = IDLE;
                end else begin
                    load    = 1'b1;
                    state_d = RUN_UP;
                end
            end
            RUN_UP: begin
                presc_d = terminal ? '0 : presc_q + 1'b1;
                if (bus.stop) begin
                    syn_clr = 1'b1;
                    presc_d = '0;
                    state_d = IDLE;
                end else if (terminal) begin
                    en = 1'b1;
                    // reverse at the top instead of wrapping
                    if (bus.max_tick) begin
                        up      = 1'b0;
                        state_d = RUN_DN;
                    end
                end
            end
            RUN_DN: begin
                up      = 1'b0;
                presc_d = terminal ? '0 : presc_q + 1'b1;
                if (bus.stop) begin
                    syn_clr = 1'b1;
                    presc_d = '0;
                    state_d = IDLE;
                end else if (terminal) begin
                    en = 1'b1;
                    // bottom reached: sweep complete, head back up
                    if (bus.min_tick) begin
                        up      = 1'b1;
                        done    = 1'b1;
                        state_d = RUN_UP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            presc_q <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            presc_q <= presc_d;
            d_q     <= d_d;
        end
    end

`ifdef SWEEP_CTRL_SWEEP_CNT_EN
    logic [15:0] sweeps_q, sweeps_d;

    always_comb begin
        sweeps_d = sweeps_q;
        if (done && (sweeps_q != 16'hFFFF)) begin
            sweeps_d = sweeps_q + 16'd1;
        end
    end

    // survives stop/start; only reset clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            sweeps_q <= '0;
        end else begin
            sweeps_q <= sweeps_d;
        end
    end

    assign bus.sweeps = sweeps_q;
`else
    assign bus.sweeps = 16'h0000;
`endif

    assign bus.syn_clr    = syn_clr;
    assign bus.load       = load;
    assign bus.en         = en;
    assign bus.up         = up;
    assign bus.d          = d_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.sweep_done = done;

endmodule
